pe_rx: RTL

PE_RX -- requirements
Module: pe_rx

---
 rtl/pe_rx_if.sv | 29 ++
 rtl/pe_rx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pe_rx_if.sv
// rtl/pe_rx_if.sv - input beat / result handshake bundle for the pe_rx processing element
interface pe_rx_if #(
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32
);
    logic [1:0]               mode;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [MUL_BW-1:0] x_i;
    logic signed [MUL_BW-1:0] wc_i;
    logic signed [ACC_BW-1:0] o_i;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_BW-1:0] mac_o;
    logic                     sat_o;
    logic signed [MUL_BW-1:0] wc_o;
    logic signed [MUL_BW-1:0] x_o;

    modport master (
        output mode, in_valid, x_i, wc_i, o_i, flush, out_ready,
        input  in_ready, out_valid, mac_o, sat_o, wc_o, x_o
    );

    modport slave (
        input  mode, in_valid, x_i, wc_i, o_i, flush, out_ready,
        output in_ready, out_valid, mac_o, sat_o, wc_o, x_o
    );
endinterface

// File: rtl/pe_rx.sv
// rtl/pe_rx.sv - systolic PE: gemm MAC or Horner-style unary evaluation; PE_RX_SAT_EN selects saturating arithmetic
module pe_rx #(
    parameter int INT_BW   = 5,
    parameter int FRA_BW   = 10,
    parameter int MUL_BW   = 16,
    parameter int ACC_BW   = 32,
    parameter int UNO_ITER = 4
) (
    input logic  clk,
    input logic  rst_n,
    pe_rx_if.slave bus
);
    localparam int                CNT_W     = (UNO_ITER > 1) ? $clog2(UNO_ITER) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(UNO_ITER - 1);
    localparam logic [1:0]        MODE_GEMM = 2'b00;
`ifdef PE_RX_SAT_EN
    localparam logic signed [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};
    localparam logic signed [MUL_BW-1:0] MUL_MAX = {1'b0, {(MUL_BW-1){1'b1}}};
    localparam logic signed [MUL_BW-1:0] MUL_MIN = {1'b1, {(MUL_BW-1){1'b0}}};
`endif

    if (MUL_BW < INT_BW + FRA_BW + 1 || ACC_BW < 2 * MUL_BW || UNO_ITER < 2) begin : g_bad_params
        $error("pe_rx: illegal parameter combination");
    end

    typedef enum logic [0:0] {IDLE, UNO} state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic signed [MUL_BW-1:0] acc_q, acc_d;
    logic signed [MUL_BW-1:0] xreg_q, xreg_d;
    logic signed [MUL_BW-1:0] wc_q, wc_d;
    logic signed [MUL_BW-1:0] x_q, x_d;
    logic [1:0]               uno_mode_q, uno_mode_d;
    logic                     sat_acc_q, sat_acc_d;
    logic                     out_valid_q, out_valid_d;
    logic                     sat_q, sat_d;
    logic signed [ACC_BW-1:0] mac_q, mac_d;

    logic                       in_ready;
    logic                       accept;
    logic signed [2*MUL_BW-1:0] gemm_prod;
    logic signed [ACC_BW:0]     gemm_sum;
    logic signed [ACC_BW-1:0]   gemm_res;
    logic                       gemm_sat;
    logic signed [2*MUL_BW-1:0] uno_prod;
    logic signed [2*MUL_BW-1:0] uno_shift;
    logic signed [2*MUL_BW:0]   uno_sum;
    logic signed [MUL_BW-1:0]   uno_res;
    logic                       uno_sat;

    assign in_ready = ~out_valid_q | bus.out_ready;
    assign accept   = bus.in_valid & in_ready;

    // Sums are formed one bit wider than the target so overflow is visible in the top bits.
    always_comb begin
        gemm_prod = {{MUL_BW{bus.wc_i[MUL_BW-1]}}, bus.wc_i} * {{MUL_BW{bus.x_i[MUL_BW-1]}}, bus.x_i};
        gemm_sum  = {{(ACC_BW+1-2*MUL_BW){gemm_prod[2*MUL_BW-1]}}, gemm_prod}
                  + {bus.o_i[ACC_BW-1], bus.o_i};
        uno_prod  = {{MUL_BW{acc_q[MUL_BW-1]}}, acc_q} * {{MUL_BW{xreg_q[MUL_BW-1]}}, xreg_q};
        uno_shift = uno_prod >>> FRA_BW;
        uno_sum   = {uno_shift[2*MUL_BW-1], uno_shift}
                  + {{(MUL_BW+1){bus.wc_i[MUL_BW-1]}}, bus.wc_i};
`ifdef PE_RX_SAT_EN
        gemm_sat  = gemm_sum[ACC_BW] ^ gemm_sum[ACC_BW-1];
        gemm_res  = gemm_sat ? (gemm_sum[ACC_BW] ? ACC_MIN : ACC_MAX) : ACC_BW'(gemm_sum);
        uno_sat   = !((&uno_sum[2*MUL_BW:MUL_BW-1]) || !(|uno_sum[2*MUL_BW:MUL_BW-1]));
        uno_res   = uno_sat ? (uno_sum[2*MUL_BW] ? MUL_MIN : MUL_MAX) : MUL_BW'(uno_sum);
`else
        gemm_sat  = 1'b0;
        gemm_res  = ACC_BW'(gemm_sum);
        uno_sat   = 1'b0;
        uno_res   = MUL_BW'(uno_sum);
`endif
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        xreg_d      = xreg_q;
        wc_d        = wc_q;
        x_d         = x_q;
        uno_mode_d  = uno_mode_q;
        sat_acc_d   = sat_acc_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;
        mac_d       = mac_q;

        // The systolic forward registers load even when a flush drops the beat.
        if (accept) begin
            wc_d = bus.wc_i;
            x_d  = bus.x_i;
        end
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.mode == MODE_GEMM) begin
                        out_valid_d = 1'b1;
                        mac_d       = gemm_res;
                        sat_d       = gemm_sat;
                    end else begin
                        acc_d      = bus.wc_i;
                        xreg_d     = bus.x_i;
                        cnt_d      = CNT_W'(1);
                        uno_mode_d = bus.mode;
                        sat_acc_d  = 1'b0;
                        state_d    = UNO;
                    end
                end
            end
            UNO: begin
                if (bus.flush) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    acc_d     = '0;
                    sat_acc_d = 1'b0;
                end else if (accept && uno_mode_q != MODE_GEMM) begin
                    acc_d = uno_res;
                    if (cnt_q == CNT_LAST) begin
                        out_valid_d = 1'b1;
                        mac_d       = {{(ACC_BW-MUL_BW){uno_res[MUL_BW-1]}}, uno_res};
                        sat_d       = sat_acc_q | uno_sat;
                        sat_acc_d   = 1'b0;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end else begin
                        sat_acc_d = sat_acc_q | uno_sat;
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            xreg_q      <= '0;
            wc_q        <= '0;
            x_q         <= '0;
            uno_mode_q  <= '0;
            sat_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            mac_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            xreg_q      <= xreg_d;
            wc_q        <= wc_d;
            x_q         <= x_d;
            uno_mode_q  <= uno_mode_d;
            sat_acc_q   <= sat_acc_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
            mac_q       <= mac_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.mac_o     = mac_q;
    assign bus.sat_o     = sat_q;
    assign bus.wc_o      = wc_q;
    assign bus.x_o       = x_q;
endmodule
